mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency memory between the instruction-fetch requester (IF) and the load/store requester (MEM). It also generates the fetch-stage stall while an IF access is pending. It honours branch redirects by discarding stale in-flight fetch responses. It sits between the fetch/memory stages and the unified memory port.

Parameters:
LATENCY, 2, cycles from port grant to port_rdata valid; legal range 1..15.
STARVE_LIMIT, 4, consecutive MEM-won conflicts before IF is forced to win; legal range 1..15.

Ports:
clk  in  1  clock; all flops on posedge
nrst  in  1  asynchronous active-low reset
if_req  in  1  fetch requests a read at if_addr
if_addr  in  Constants::WIDTH  fetch byte address
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  if_rdata valid this cycle
if_rdata  out  Constants::WIDTH  fetched instruction word
if_stall  out  1  fetch must hold its PC
branch_taken_ex  in  1  redirect; kills any in-flight IF response
mem_req  in  1  load/store request
mem_we  in  1  1 = store, 0 = load
mem_addr  in  Constants::WIDTH  data byte address
mem_wdata  in  Constants::WIDTH  store data
mem_gnt  out  1  MEM request accepted this cycle
mem_rvalid  out  1  load data valid or store complete
mem_rdata  out  Constants::WIDTH  load data (0 for stores)
port_req  out  1  access issued to memory this cycle
port_we  out  1  write enable to memory
port_addr  out  Constants::WIDTH  memory address
port_wdata  out  Constants::WIDTH  memory write data
port_rdata  in  Constants::WIDTH  memory read data, valid LATENCY cycles after port_req

Behaviour:
- Clock and reset: single clock clk. Reset nrst is asynchronous, active-low.
- Reset: state=IDLE, cnt=0, starve=0, kill=0.
  - While nrst=0, all outputs are 0, including the combinational gnt, rvalid and port_* outputs.
  - An access in flight when reset asserts is discarded; no rvalid follows.
- States:
  - IDLE: port free.
  - BUSY_IF: IF access in flight.
  - BUSY_MEM: MEM access in flight.
- IDLE, no request: port_req=0 and both gnt=0.
- IDLE, one request: grant it combinationally in the same cycle.
  - port_req=1; port_* is muxed from the winner; winner's gnt=1.
  - cnt loads LATENCY-1; go to BUSY_IF or BUSY_MEM accordingly.
- IDLE, both request: MEM wins unless starve==STARVE_LIMIT, in which case IF wins.
- Starve counter:
  - MEM win with if_req=1 increments starve, saturating at STARVE_LIMIT.
  - Any IF grant clears starve.
- BUSY_x:
  - port_req=0 and no grants.
  - cnt decrements each cycle.
  - On the cycle cnt==0, x_rvalid=1 and x_rdata=port_rdata (combinational passthrough); next state is IDLE.
  - Stores pulse mem_rvalid with mem_rdata=0.
- Timing: grant at cycle t gives rvalid at t+LATENCY. Earliest next grant is t+LATENCY+1.
- if_stall = if_req & ~if_rvalid (combinational). It covers both lost arbitration and an outstanding access.
- Branch redirect:
  - branch_taken_ex=1 during BUSY_IF sets kill. The killed response has if_rvalid=0, and the port still waits out the latency.
  - kill clears on return to IDLE.
  - branch_taken_ex in the same cycle as an IF grant in IDLE: the grant still occurs and kill is set.
  - branch_taken_ex on the rvalid cycle itself suppresses that rvalid.
- Address rule: addresses are passed unmodified; alignment is the requester's responsibility.

Optional Feature:
ARB_PERF_COUNTERS_EN
- Defined: adds outputs perf_if_stall_cycles and perf_conflicts, each 32-bit and saturating at 32'hffff_ffff, both reset to 0.
  - perf_if_stall_cycles counts cycles with if_stall=1.
  - perf_conflicts counts IDLE cycles with if_req&mem_req.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package Arbiter holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, BUSY_IF, BUSY_MEM}
  - localparam CNT_W=4
  - widths taken from Constants::WIDTH
- Sub-module arb_latency_timer: loadable down-counter with a load input, a value input and a zero flag. It is the natural split from the FSM/mux top.

Test Plan:
- LATENCY=2, IF only, if_addr=32'h0000_0010, memory returns 32'h2402_0005 at t+2 → if_gnt at t, if_rvalid=1 with if_rdata=32'h2402_0005 at t+2, if_stall=1 at t..t+1, next grant t+3.
- Simultaneous if_req and mem_req (load, addr 32'h40) held continuously, STARVE_LIMIT=4 → MEM granted 4 times, 5th arbitration grants IF, starve returns to 0.
- Store mem_we=1, mem_addr=32'h80, mem_wdata=32'hdead_beef → port_we=1, port_wdata=32'hdead_beef at grant, mem_rvalid=1 with mem_rdata=0 at t+2.
- IF granted at t, branch_taken_ex pulse at t+1 → no if_rvalid at t+2, state IDLE at t+3, a new IF request granted at t+3.
- nrst low at t+1 of an IF access → all outputs 0 immediately, no rvalid after release, first grant on the first IDLE cycle after release.
- With ARB_PERF_COUNTERS_EN, 3 conflict cycles and 7 stall cycles → perf_conflicts=3, perf_if_stall_cycles=7.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the IF/MEM single-port memory arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PERF_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_t;

  // Command presented on the memory port by the arbitration winner
  typedef struct packed {
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
  } port_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-port signals of the arbiter.
// slave: arbiter view; master: requester/memory view.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [WIDTH-1:0] if_rdata;
  logic             if_stall;
  logic             branch_taken_ex;

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;

  logic             port_req;
  logic             port_we;
  logic [WIDTH-1:0] port_addr;
  logic [WIDTH-1:0] port_wdata;
  logic [WIDTH-1:0] port_rdata;

  modport slave (
    input  if_req, if_addr, branch_taken_ex,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  port_rdata,
    output if_gnt, if_rvalid, if_rdata, if_stall,
    output mem_gnt, mem_rvalid, mem_rdata,
    output port_req, port_we, port_addr, port_wdata
  );

  modport master (
    output if_req, if_addr, branch_taken_ex,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output port_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_stall,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  port_req, port_we, port_addr, port_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_latency_timer.sv
// Loadable down-counter tracking the remaining memory latency of the access in flight.
module arb_latency_timer
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;

  // Counts down to zero and parks there until reloaded
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between fetch (IF) and load/store (MEM).
// Optional ARB_PERF_COUNTERS_EN adds saturating stall/conflict counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  mem_port_arbiter_if.slave     bus
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [PERF_W-1:0]     perf_if_stall_cycles,
  output logic [PERF_W-1:0]     perf_conflicts
`endif
);

  localparam logic [CNT_W-1:0] LOAD_VAL  = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] STARVE_MX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             kill_q, kill_d;
  logic             store_q, store_d;
  logic             timer_load;
  logic             timer_zero_c;
  logic             if_win_c;
  logic             if_rvalid_c;
  port_cmd_t        cmd_c;

  arb_latency_timer u_timer (
    .clk    (clk),
    .nrst   (nrst),
    .load   (timer_load),
    .value  (LOAD_VAL),
    .zero_c (timer_zero_c)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      kill_q   <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      kill_q   <= kill_d;
      store_q  <= store_d;
    end
  end

  // Next state, arbitration and port mux; every output is forced low while in reset
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    kill_d      = kill_q;
    store_d     = store_q;
    timer_load  = 1'b0;
    if_rvalid_c = 1'b0;

    bus.if_gnt     = 1'b0;
    bus.if_rdata   = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.port_req   = 1'b0;
    bus.port_we    = 1'b0;
    bus.port_addr  = '0;
    bus.port_wdata = '0;

    if_win_c = bus.if_req & (~bus.mem_req | (starve_q == STARVE_MX));
    if (if_win_c) begin
      cmd_c.we    = 1'b0;
      cmd_c.addr  = bus.if_addr;
      cmd_c.wdata = '0;
    end else begin
      cmd_c.we    = bus.mem_we;
      cmd_c.addr  = bus.mem_addr;
      cmd_c.wdata = bus.mem_wdata;
    end

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (nrst && (bus.if_req || bus.mem_req)) begin
          bus.port_req   = 1'b1;
          bus.port_we    = cmd_c.we;
          bus.port_addr  = cmd_c.addr;
          bus.port_wdata = cmd_c.wdata;
          timer_load     = 1'b1;
          if (if_win_c) begin
            bus.if_gnt = 1'b1;
            starve_d   = '0;
            kill_d     = bus.branch_taken_ex;
            state_d    = BUSY_IF;
          end else begin
            bus.mem_gnt = 1'b1;
            store_d     = bus.mem_we;
            state_d     = BUSY_MEM;
            if (bus.if_req && (starve_q != STARVE_MX)) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end
        end
      end
      BUSY_IF: begin
        if (bus.branch_taken_ex) begin
          kill_d = 1'b1;
        end
        if (timer_zero_c) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          // A redirect now or earlier in the access drops the response
          if (nrst && !kill_q && !bus.branch_taken_ex) begin
            if_rvalid_c  = 1'b1;
            bus.if_rdata = bus.port_rdata;
          end
        end
      end
      BUSY_MEM: begin
        if (timer_zero_c) begin
          state_d = IDLE;
          if (nrst) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = store_q ? '0 : bus.port_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bus.if_rvalid = if_rvalid_c;
    bus.if_stall  = nrst & bus.if_req & ~if_rvalid_c;
  end

`ifdef ARB_PERF_COUNTERS_EN
  // Saturating event counters
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_if_stall_cycles <= '0;
      perf_conflicts       <= '0;
    end else begin
      if (bus.if_stall && (perf_if_stall_cycles != '1)) begin
        perf_if_stall_cycles <= perf_if_stall_cycles + PERF_W'(1);
      end
      if ((state_q == IDLE) && bus.if_req && bus.mem_req && (perf_conflicts != '1)) begin
        perf_conflicts <= perf_conflicts + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a fixed-latency memory model and response scoreboard.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned LAT  = 2;
  localparam int unsigned SLIM = 4;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] pipe [16] = '{default: 32'h0};
  logic        cap_req = 1'b0;
  logic        cap_we  = 1'b0;
  logic [31:0] cap_addr  = 32'h0;
  logic [31:0] cap_wdata = 32'h0;

  mem_port_arbiter_if ifc ();

`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_conf;
`endif

  mem_port_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifc)
`ifdef ARB_PERF_COUNTERS_EN
    ,
    .perf_if_stall_cycles (perf_stall),
    .perf_conflicts       (perf_conf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'h5a5a_0000;
  endfunction

  // Memory model: capture the settled port command late in the cycle, answer LAT cycles later
  always @(negedge clk) begin
    #3;
    cap_req   = ifc.port_req;
    cap_we    = ifc.port_we;
    cap_addr  = ifc.port_addr;
    cap_wdata = ifc.port_wdata;
  end

  always @(posedge clk) begin
    for (int i = 15; i > 1; i--) pipe[i] = pipe[i-1];
    if (cap_req && !cap_we) pipe[1] = mem_val(cap_addr);
    else                    pipe[1] = 32'hbad0_0000 | cap_addr;
    if (cap_req && cap_we) mem_arr[cap_addr] = cap_wdata;
  end

  assign ifc.port_rdata = pipe[LAT];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    logic [31:0] q;
    nrst = 1'b0;
    ifc.if_req = 1'b1; ifc.if_addr = 32'h10; ifc.branch_taken_ex = 1'b0;
    ifc.mem_req = 1'b1; ifc.mem_we = 1'b1; ifc.mem_addr = 32'h44; ifc.mem_wdata = 32'h1234_5678;
    @(negedge clk); #1;
    q = {ifc.if_gnt, ifc.if_rvalid, ifc.if_stall, ifc.mem_gnt, ifc.mem_rvalid, ifc.port_req, ifc.port_we} |
        ifc.if_rdata | ifc.mem_rdata | ifc.port_addr | ifc.port_wdata;
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", q); end
`ifdef ARB_PERF_COUNTERS_EN
    checks++;
    if ({perf_stall, perf_conf} !== 64'h0) begin
      errors++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_stall, perf_conf);
    end
`endif
    ifc.if_req = 1'b0; ifc.mem_req = 1'b0; ifc.mem_we = 1'b0;
    @(negedge clk);
    nrst = 1'b1; #1;
    checks++;
    if ({ifc.port_req, ifc.if_gnt, ifc.mem_gnt, ifc.if_stall} !== 4'b0) begin
      errors++; $display("FAIL idle_no_req: got %b want 0000", {ifc.port_req, ifc.if_gnt, ifc.mem_gnt, ifc.if_stall});
    end
  endtask

  task automatic test_if_only();
    logic [31:0] w;
    @(negedge clk);
    ifc.if_req = 1'b1; ifc.if_addr = 32'h0000_0010; #1;
    checks++;
    if ({ifc.if_gnt, ifc.mem_gnt, ifc.port_req, ifc.port_we, ifc.if_stall} !== 5'b10101) begin
      errors++; $display("FAIL if_grant: got %b want 10101", {ifc.if_gnt, ifc.mem_gnt, ifc.port_req, ifc.port_we, ifc.if_stall});
    end
    checks++;
    if (ifc.port_addr !== 32'h10) begin errors++; $display("FAIL if_port_addr: got %h want 10", ifc.port_addr); end
    if_q.push_back(32'h2402_0005);
    @(negedge clk); #1;
    checks++;
    if ({ifc.if_gnt, ifc.port_req, ifc.if_rvalid, ifc.if_stall} !== 4'b0001) begin
      errors++; $display("FAIL if_wait: got %b want 0001", {ifc.if_gnt, ifc.port_req, ifc.if_rvalid, ifc.if_stall});
    end
    @(negedge clk);
    ifc.if_addr = 32'h14; #1;
    checks++;
    if ({ifc.if_rvalid, ifc.if_stall, ifc.if_gnt} !== 3'b100) begin
      errors++; $display("FAIL if_rvalid: got %b want 100", {ifc.if_rvalid, ifc.if_stall, ifc.if_gnt});
    end
    if (ifc.if_rvalid === 1'b1) begin
      w = (if_q.size() > 0) ? if_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (ifc.if_rdata !== w) begin errors++; $display("FAIL if_rdata: got %h want %h", ifc.if_rdata, w); end
    end
    @(negedge clk); #1;
    checks++;
    if (ifc.if_gnt !== 1'b1) begin errors++; $display("FAIL if_next_grant: got %b want 1", ifc.if_gnt); end
    if_q.push_back(mem_val(32'h14));
    @(negedge clk);
    ifc.if_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({ifc.if_rvalid, ifc.if_stall} !== 2'b10) begin
      errors++; $display("FAIL if_second_rvalid: got %b want 10", {ifc.if_rvalid, ifc.if_stall});
    end
    if (ifc.if_rvalid === 1'b1) begin
      w = (if_q.size() > 0) ? if_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (ifc.if_rdata !== w) begin errors++; $display("FAIL if_second_rdata: got %h want %h", ifc.if_rdata, w); end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] w;
    @(negedge clk);
    ifc.mem_req = 1'b1; ifc.mem_we = 1'b1; ifc.mem_addr = 32'h80; ifc.mem_wdata = 32'hdead_beef; #1;
    checks++;
    if ({ifc.mem_gnt, ifc.if_gnt, ifc.port_req, ifc.port_we} !== 4'b1011) begin
      errors++; $display("FAIL store_grant: got %b want 1011", {ifc.mem_gnt, ifc.if_gnt, ifc.port_req, ifc.port_we});
    end
    checks++;
    if ({ifc.port_addr, ifc.port_wdata} !== {32'h80, 32'hdead_beef}) begin
      errors++; $display("FAIL store_port: got %h/%h want 80/deadbeef", ifc.port_addr, ifc.port_wdata);
    end
    mem_q.push_back(32'h0);
    @(negedge clk); #1;
    checks++;
    if ({ifc.mem_gnt, ifc.mem_rvalid} !== 2'b00) begin
      errors++; $display("FAIL store_wait: got %b want 00", {ifc.mem_gnt, ifc.mem_rvalid});
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 1) ifc.mem_req = 1'b0;
      #1;
      checks++;
      if (ifc.mem_rvalid !== 1'b1) begin errors++; $display("FAIL mem_rvalid_%0d: got %b want 1", k, ifc.mem_rvalid); end
      if (ifc.mem_rvalid === 1'b1) begin
        w = (mem_q.size() > 0) ? mem_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (ifc.mem_rdata !== w) begin errors++; $display("FAIL mem_rdata_%0d: got %h want %h", k, ifc.mem_rdata, w); end
      end
      if (k == 1) break;
      @(negedge clk);
      ifc.mem_we = 1'b0; #1;
      checks++;
      if ({ifc.mem_gnt, ifc.port_we, ifc.port_addr} !== {2'b10, 32'h80}) begin
        errors++; $display("FAIL load_grant: got %b/%b/%h want 1/0/80", ifc.mem_gnt, ifc.port_we, ifc.port_addr);
      end
      mem_q.push_back(32'hdead_beef);
      @(negedge clk);
    end
  endtask

  task automatic test_starvation();
    int          starve = 0;
    logic        exp_if;
    logic [31:0] w;
    @(negedge clk);
    ifc.if_req = 1'b1; ifc.if_addr = 32'h10;
    ifc.mem_req = 1'b1; ifc.mem_we = 1'b0; ifc.mem_addr = 32'h40;
    for (int r = 0; r < 6; r++) begin
      if (r != 0) @(negedge clk);
      #1;
      exp_if = (starve == SLIM);
      checks++;
      if ({ifc.if_gnt, ifc.mem_gnt} !== {exp_if, ~exp_if}) begin
        errors++; $display("FAIL starve_round_%0d: got if/mem %b%b want %b%b", r, ifc.if_gnt, ifc.mem_gnt, exp_if, ~exp_if);
      end
      if (exp_if) begin if_q.push_back(32'h2402_0005); starve = 0; end
      else begin mem_q.push_back(mem_val(32'h40)); if (starve < SLIM) starve++; end
      @(negedge clk); #1;
      checks++;
      if ({ifc.if_gnt, ifc.mem_gnt, ifc.if_stall} !== 3'b001) begin
        errors++; $display("FAIL starve_busy_%0d: got %b want 001", r, {ifc.if_gnt, ifc.mem_gnt, ifc.if_stall});
      end
      @(negedge clk); #1;
      checks++;
      if ({ifc.if_rvalid, ifc.mem_rvalid} !== {exp_if, ~exp_if}) begin
        errors++; $display("FAIL starve_rvalid_%0d: got %b%b want %b%b", r, ifc.if_rvalid, ifc.mem_rvalid, exp_if, ~exp_if);
      end
      if (ifc.if_rvalid === 1'b1) begin
        w = (if_q.size() > 0) ? if_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (ifc.if_rdata !== w) begin errors++; $display("FAIL starve_if_rdata_%0d: got %h want %h", r, ifc.if_rdata, w); end
      end
      if (ifc.mem_rvalid === 1'b1) begin
        w = (mem_q.size() > 0) ? mem_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (ifc.mem_rdata !== w) begin errors++; $display("FAIL starve_mem_rdata_%0d: got %h want %h", r, ifc.mem_rdata, w); end
      end
    end
    @(negedge clk);
    ifc.if_req = 1'b0; ifc.mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_branch();
    logic [31:0] w;
    // Redirect one cycle after the grant
    @(negedge clk);
    ifc.if_req = 1'b1; ifc.if_addr = 32'h20; #1;
    checks++;
    if (ifc.if_gnt !== 1'b1) begin errors++; $display("FAIL br_grant: got %b want 1", ifc.if_gnt); end
    @(negedge clk); ifc.branch_taken_ex = 1'b1;
    @(negedge clk); ifc.branch_taken_ex = 1'b0; #1;
    checks++;
    if ({ifc.if_rvalid, ifc.if_stall} !== 2'b01) begin
      errors++; $display("FAIL br_killed: got %b want 01", {ifc.if_rvalid, ifc.if_stall});
    end
    @(negedge clk); ifc.if_addr = 32'h100; #1;
    checks++;
    if (ifc.if_gnt !== 1'b1) begin errors++; $display("FAIL br_regrant: got %b want 1", ifc.if_gnt); end
    if_q.push_back(mem_val(32'h100));
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (ifc.if_rvalid !== 1'b1) begin errors++; $display("FAIL br_target_rvalid: got %b want 1", ifc.if_rvalid); end
    if (ifc.if_rvalid === 1'b1) begin
      w = (if_q.size() > 0) ? if_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (ifc.if_rdata !== w) begin errors++; $display("FAIL br_target_rdata: got %h want %h", ifc.if_rdata, w); end
    end
    // Redirect in the same cycle as the grant
    @(negedge clk); ifc.if_addr = 32'h30; ifc.branch_taken_ex = 1'b1; #1;
    checks++;
    if (ifc.if_gnt !== 1'b1) begin errors++; $display("FAIL br_same_grant: got %b want 1", ifc.if_gnt); end
    @(negedge clk); ifc.branch_taken_ex = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (ifc.if_rvalid !== 1'b0) begin errors++; $display("FAIL br_same_killed: got %b want 0", ifc.if_rvalid); end
    // Redirect on the response cycle itself
    @(negedge clk); ifc.if_addr = 32'h34; #1;
    checks++;
    if (ifc.if_gnt !== 1'b1) begin errors++; $display("FAIL br_late_grant: got %b want 1", ifc.if_gnt); end
    @(negedge clk);
    @(negedge clk); ifc.branch_taken_ex = 1'b1; #1;
    checks++;
    if (ifc.if_rvalid !== 1'b0) begin errors++; $display("FAIL br_late_killed: got %b want 0", ifc.if_rvalid); end
    @(negedge clk); ifc.branch_taken_ex = 1'b0; ifc.if_addr = 32'h38; #1;
    checks++;
    if (ifc.if_gnt !== 1'b1) begin errors++; $display("FAIL br_after_grant: got %b want 1", ifc.if_gnt); end
    if_q.push_back(mem_val(32'h38));
    @(negedge clk); ifc.if_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (ifc.if_rvalid !== 1'b1) begin errors++; $display("FAIL br_after_rvalid: got %b want 1", ifc.if_rvalid); end
    if (ifc.if_rvalid === 1'b1) begin
      w = (if_q.size() > 0) ? if_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (ifc.if_rdata !== w) begin errors++; $display("FAIL br_after_rdata: got %h want %h", ifc.if_rdata, w); end
    end
  endtask

  task automatic test_reset_in_flight();
    logic [31:0] q;
    logic [31:0] w;
    @(negedge clk);
    ifc.if_req = 1'b1; ifc.if_addr = 32'h44; #1;
    checks++;
    if (ifc.if_gnt !== 1'b1) begin errors++; $display("FAIL rst_grant: got %b want 1", ifc.if_gnt); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); nrst = 1'b0; #1;
      q = {ifc.if_gnt, ifc.if_rvalid, ifc.if_stall, ifc.mem_gnt, ifc.mem_rvalid, ifc.port_req, ifc.port_we} |
          ifc.if_rdata | ifc.mem_rdata | ifc.port_addr | ifc.port_wdata;
      checks++;
      if (q !== 32'h0) begin errors++; $display("FAIL rst_outputs_%0d: got %h want 0", k, q); end
    end
    @(negedge clk);
    nrst = 1'b1; ifc.if_addr = 32'h48; #1;
    checks++;
    if ({ifc.if_gnt, ifc.if_rvalid, ifc.port_addr} !== {2'b10, 32'h48}) begin
      errors++; $display("FAIL rst_release_grant: got %b/%b/%h want 1/0/48", ifc.if_gnt, ifc.if_rvalid, ifc.port_addr);
    end
    if_q.push_back(mem_val(32'h48));
    @(negedge clk); ifc.if_req = 1'b0; #1;
    checks++;
    if (ifc.if_rvalid !== 1'b0) begin errors++; $display("FAIL rst_no_stale: got %b want 0", ifc.if_rvalid); end
    @(negedge clk); #1;
    checks++;
    if (ifc.if_rvalid !== 1'b1) begin errors++; $display("FAIL rst_new_rvalid: got %b want 1", ifc.if_rvalid); end
    if (ifc.if_rvalid === 1'b1) begin
      w = (if_q.size() > 0) ? if_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (ifc.if_rdata !== w) begin errors++; $display("FAIL rst_new_rdata: got %h want %h", ifc.if_rdata, w); end
    end
  endtask

`ifdef ARB_PERF_COUNTERS_EN
  task automatic test_perf();
    @(negedge clk); nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    ifc.if_req = 1'b1; ifc.if_addr = 32'h10;
    ifc.mem_req = 1'b1; ifc.mem_we = 1'b0; ifc.mem_addr = 32'h40;
    for (int k = 0; k < 6; k++) @(negedge clk);
    @(negedge clk);
    ifc.if_req = 1'b0; ifc.mem_req = 1'b0; #1;
    checks++;
    if (perf_conf !== 32'd3) begin errors++; $display("FAIL perf_conflicts: got %0d want 3", perf_conf); end
    checks++;
    if (perf_stall !== 32'd7) begin errors++; $display("FAIL perf_stall: got %0d want 7", perf_stall); end
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    mem_arr[32'h10] = 32'h2402_0005;
    test_reset();
    test_if_only();
    test_store_load();
    test_starvation();
    test_branch();
    test_reset_in_flight();
`ifdef ARB_PERF_COUNTERS_EN
    test_perf();
`endif
    checks++;
    if ((if_q.size() + mem_q.size()) !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d/%0d outstanding want 0/0", if_q.size(), mem_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
